// File: rtl/bitcomposer_pkg.sv
// Shared constants for the bit composer: pitch half-periods in 50 MHz clock cycles
// and the note gate state encoding.
package bitcomposer_pkg;

    localparam int unsigned PITCH_A4 = 56818;
    localparam int unsigned PITCH_C5 = 47801;
    localparam int unsigned PITCH_E5 = 37936;
    localparam int unsigned PITCH_A5 = 28409;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOUND = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/tone_osc.sv
// Square-wave generator: while run is high the output toggles every half_period
// cycles; while run is low the counter is preloaded and the output held low.
module tone_osc #(
    parameter int HALF_PERIOD_W = 17
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    input  logic [HALF_PERIOD_W-1:0] half_period,
    output logic                     wave
);

    logic [HALF_PERIOD_W-1:0] count;

    // Counts half_period down to 1 so every half-wave, including the first, lasts
    // exactly half_period cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            wave  <= 1'b0;
        end else if (!run) begin
            count <= half_period;
            wave  <= 1'b0;
        end else if (count <= HALF_PERIOD_W'(1)) begin
            count <= half_period;
            wave  <= ~wave;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/note_gate_player.sv
// Plays one gated note per enabled beat step: a fixed-length tone followed by a
// short forced silence, with re-strike during the tone and a wrapping note counter.
module note_gate_player
    import bitcomposer_pkg::*;
#(
    parameter int          HALF_PERIOD_W = 17,
    parameter int          GATE_CYCLES   = 10000000,
    parameter int          GAP_CYCLES    = 500000,
    parameter int unsigned PITCH_0       = PITCH_A4,
    parameter int unsigned PITCH_1       = PITCH_C5,
    parameter int unsigned PITCH_2       = PITCH_E5,
    parameter int unsigned PITCH_3       = PITCH_A5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       beat_clk,
    input  logic       play,
    input  logic [3:0] beat,
    input  logic [1:0] pitch_sel,
    output logic       speaker,
    output logic       busy,
    output logic [7:0] note_count
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    state_t                   state, state_next;
    logic                     beat_clk_p1;
    logic                     armed;
    logic [GATE_W-1:0]        gate_cnt;
    logic [GAP_W-1:0]         gap_cnt;
    logic [HALF_PERIOD_W-1:0] pitch_latched;
    logic [HALF_PERIOD_W-1:0] pitch_next;
    logic                     step_edge, trigger, accept;
    logic                     gate_done, gap_done;
    logic                     wave;

    function automatic logic [HALF_PERIOD_W-1:0] pitch_lookup(input logic [1:0] sel,
                                                             input logic       accent);
        logic [HALF_PERIOD_W-1:0] p;
        case (sel)
            2'd0:    p = HALF_PERIOD_W'(PITCH_0);
            2'd1:    p = HALF_PERIOD_W'(PITCH_1);
            2'd2:    p = HALF_PERIOD_W'(PITCH_2);
            default: p = HALF_PERIOD_W'(PITCH_3);
        endcase
        return accent ? (p >> 1) : p;
    endfunction

    // armed stays low after reset until beat_clk has been seen low, so a beat_clk
    // already high at reset release is not mistaken for a new step.
    assign step_edge  = beat_clk & ~beat_clk_p1 & armed;
    assign trigger    = step_edge & play;
    assign accept     = trigger & (state != GAP);
    assign gate_done  = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign pitch_next = accept ? pitch_lookup(pitch_sel, (beat & 4'b0011) == 4'd0)
                               : pitch_latched;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = SOUND;
            SOUND:   if (!trigger && gate_done) state_next = GAP;
            GAP:     if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_clk_p1   <= 1'b0;
            armed         <= 1'b0;
            gate_cnt      <= '0;
            gap_cnt       <= '0;
            pitch_latched <= '0;
            note_count    <= '0;
        end else begin
            beat_clk_p1   <= beat_clk;
            if (!beat_clk) armed <= 1'b1;
            pitch_latched <= pitch_next;
            if (accept) note_count <= note_count + 8'd1;
            gate_cnt <= (state == SOUND && !trigger && !gate_done) ? gate_cnt + 1'b1 : '0;
            gap_cnt  <= (state == GAP && !gap_done) ? gap_cnt + 1'b1 : '0;
        end
    end

    // pitch_next lets the oscillator preload the new half-period in the trigger cycle.
    tone_osc #(
        .HALF_PERIOD_W(HALF_PERIOD_W)
    ) u_tone_osc (
        .clock      (clock),
        .reset      (reset),
        .run        (state == SOUND),
        .half_period(pitch_next),
        .wave       (wave)
    );

    assign speaker = wave & (state == SOUND);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_note_gate_player.sv
// Directed bench for note_gate_player with a short gate, short gap and small pitch table.
module tb_note_gate_player;

    localparam int GATE = 20;
    localparam int GAPC = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       beat_clk;
    logic       play;
    logic [3:0] beat;
    logic [1:0] pitch_sel;
    logic       speaker;
    logic       busy;
    logic [7:0] note_count;

    int n_checks = 0;
    int n_fail   = 0;

    note_gate_player #(
        .HALF_PERIOD_W(17),
        .GATE_CYCLES  (GATE),
        .GAP_CYCLES   (GAPC),
        .PITCH_0      (4),
        .PITCH_1      (6),
        .PITCH_2      (8),
        .PITCH_3      (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .beat_clk  (beat_clk),
        .play      (play),
        .beat      (beat),
        .pitch_sel (pitch_sel),
        .speaker   (speaker),
        .busy      (busy),
        .note_count(note_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Strike one note and follow it through SOUND and GAP, optionally re-striking
    // in SOUND cycle restrike_at and striking (to be ignored) in GAP cycle gap_strike_at.
    task automatic run_note(input string tag, input logic [3:0] b, input logic [1:0] ps,
                            input int half, input int sound_len,
                            input int restrike_at, input int gap_strike_at);
        beat_clk  = 1'b1;
        play      = 1'b1;
        beat      = b;
        pitch_sel = ps;
        check_eq({tag, "_pre_busy"}, 32'(busy), 0);
        tick();
        beat_clk = 1'b0;
        play     = 1'b0;
        for (int k = 1; k <= sound_len; k++) begin
            check_eq({tag, "_busy"}, 32'(busy), 1);
            check_eq({tag, "_spk"}, 32'(speaker), ((k - 1) / half) % 2);
            if (k == restrike_at) begin
                beat_clk = 1'b1;
                play     = 1'b1;
            end
            tick();
            beat_clk = 1'b0;
            play     = 1'b0;
        end
        for (int g = 1; g <= GAPC; g++) begin
            check_eq({tag, "_gap_busy"}, 32'(busy), 1);
            check_eq({tag, "_gap_spk"}, 32'(speaker), 0);
            if (g == gap_strike_at) begin
                beat_clk = 1'b1;
                play     = 1'b1;
            end
            tick();
            beat_clk = 1'b0;
            play     = 1'b0;
        end
        check_eq({tag, "_end_busy"}, 32'(busy), 0);
        check_eq({tag, "_end_spk"}, 32'(speaker), 0);
    endtask

    initial begin
        reset     = 1'b0;
        beat_clk  = 1'b0;
        play      = 1'b0;
        beat      = 4'd0;
        pitch_sel = 2'd0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_spk", 32'(speaker), 0);
        check_eq("rst_count", 32'(note_count), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) tick();

        run_note("base", 4'd1, 2'd0, 4, GATE, 0, 0);
        check_eq("base_count", 32'(note_count), 1);
        repeat (2) tick();

        // Step with play low, then play high without a step edge.
        beat_clk = 1'b1;
        play     = 1'b0;
        tick();
        beat_clk = 1'b0;
        play     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("noplay_busy", 32'(busy), 0);
            check_eq("noplay_spk", 32'(speaker), 0);
            tick();
        end
        play = 1'b0;
        check_eq("noplay_count", 32'(note_count), 1);
        tick();

        run_note("accent", 4'd4, 2'd0, 2, GATE, 0, 0);
        check_eq("accent_count", 32'(note_count), 2);
        tick();
        run_note("sel1", 4'd2, 2'd1, 6, GATE, 0, 0);
        check_eq("sel1_count", 32'(note_count), 3);
        tick();
        run_note("sel3acc", 4'd8, 2'd3, 5, GATE, 0, 0);
        check_eq("sel3acc_count", 32'(note_count), 4);
        tick();
        run_note("restrike", 4'd1, 2'd0, 4, 30, 10, 2);
        check_eq("restrike_count", 32'(note_count), 6);
        tick();

        // Reset in mid-tone with beat_clk held high across release.
        beat_clk  = 1'b1;
        play      = 1'b1;
        beat      = 4'd1;
        pitch_sel = 2'd0;
        tick();
        beat_clk = 1'b0;
        play     = 1'b0;
        repeat (5) tick();
        check_eq("prerst_spk", 32'(speaker), 1);
        beat_clk = 1'b1;
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_spk", 32'(speaker), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_count", 32'(note_count), 0);
        tick();
        reset = 1'b0;
        play  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("postrst_busy", 32'(busy), 0);
        end
        check_eq("postrst_count", 32'(note_count), 0);
        beat_clk = 1'b0;
        play     = 1'b0;
        tick();
        run_note("after_rst", 4'd1, 2'd0, 4, GATE, 0, 0);
        check_eq("after_rst_count", 32'(note_count), 1);

        // Counter wrap via back-to-back re-strikes.
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 255; i++) begin
            beat_clk = 1'b1;
            play     = 1'b1;
            tick();
            beat_clk = 1'b0;
            play     = 1'b0;
            tick();
        end
        check_eq("wrap_255", 32'(note_count), 255);
        beat_clk = 1'b1;
        play     = 1'b1;
        tick();
        beat_clk = 1'b0;
        play     = 1'b0;
        check_eq("wrap_0", 32'(note_count), 0);
        check_eq("wrap_busy", 32'(busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
